// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    LD_LEN  = 3'd0,
    LD_DATA = 3'd1,
    LD_CSUM = 3'd2,
    LD_DONE = 3'd3,
    LD_ERR  = 3'd4
  } loader_state_type;

  localparam logic [1:0] RV32_OPCODE_LOW = 2'b11;
  localparam int         BYTES_PER_WORD  = 4;

  // Only full-width RV32 encodings may be loaded; compressed forms are rejected.
  function automatic logic is_rv32_word(input logic [31:0] word);
    return word[1:0] == RV32_OPCODE_LOW;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; word_valid is high
// combinationally in the cycle the fourth byte is presented.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift_reg;
  logic [1:0]  byte_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (byte_valid) begin
      shift_reg    <= {byte_data, shift_reg[23:8]};
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  assign word_valid = byte_valid && (byte_cnt_reg == 2'd3);

  // The three earlier bytes sit in the shift register; the top lane is the live byte.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      if (gi == BYTES_PER_WORD - 1) begin : g_live
        assign word_data[8*gi +: 8] = byte_data;
      end else begin : g_held
        assign word_data[8*gi +: 8] = shift_reg[8*gi +: 8];
      end
    end
  endgenerate

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed instruction image into instruction memory and holds
// the core in reset until it is complete. LOADER_CHECKSUM_EN adds a trailing XOR byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  program_loader_if.master      bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0]         DEPTH_WORDS = 32'(IMEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] COUNT_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] INDEX_ONE = 1;
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_type AFTER_DATA = LD_CSUM;
`else
  localparam loader_state_type AFTER_DATA = LD_DONE;
`endif

  loader_state_type      state_reg, state_next;
  logic                  accept;
  logic                  asm_valid;
  logic                  asm_clear;
  logic                  word_valid;
  logic [31:0]           word_data;
  logic                  last_word;
  logic                  imem_we_next;

  logic [ADDR_WIDTH-1:0] word_index_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  imem_we_reg;
  logic [ADDR_WIDTH-1:0] imem_addr_reg;
  logic [31:0]           imem_wdata_reg;
  logic                  done_reg;
  logic                  error_reg;
  logic                  cpu_hold_reg;

  assign bus.rx_ready = (state_reg == LD_LEN) || (state_reg == LD_DATA) ||
                        (state_reg == LD_CSUM);
  // reload takes priority over a byte presented in the same cycle.
  assign accept    = bus.rx_valid && bus.rx_ready && !reload;
  assign asm_valid = accept && ((state_reg == LD_LEN) || (state_reg == LD_DATA));
  assign asm_clear = reload || (state_next != state_reg);
  assign last_word = ({1'b0, word_index_reg} == (count_reg - COUNT_ONE));

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  logic       csum_match;

  always_ff @(posedge clk) begin
    if (reset || reload) begin
      csum_reg <= '0;
    end else if (accept && (state_reg == LD_DATA)) begin
      csum_reg <= csum_reg ^ bus.rx_data;
    end
  end

  assign csum_match = (bus.rx_data == csum_reg);
`endif

  always_comb begin
    state_next   = state_reg;
    imem_we_next = 1'b0;
    if (reload) begin
      state_next = LD_LEN;
    end else begin
      case (state_reg)
        LD_LEN: begin
          if (word_valid) begin
            if (word_data > DEPTH_WORDS) begin
              state_next = LD_ERR;
            end else if (word_data == 32'd0) begin
              state_next = AFTER_DATA;
            end else begin
              state_next = LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (word_valid) begin
            if (!is_rv32_word(word_data)) begin
              state_next = LD_ERR;
            end else begin
              imem_we_next = 1'b1;
              if (last_word) begin
                state_next = AFTER_DATA;
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        LD_CSUM: begin
          if (accept) begin
            state_next = csum_match ? LD_DONE : LD_ERR;
          end
        end
`endif
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= LD_LEN;
      word_index_reg <= '0;
      count_reg      <= '0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      cpu_hold_reg   <= 1'b1;
    end else begin
      state_reg    <= state_next;
      imem_we_reg  <= imem_we_next;
      done_reg     <= (state_next == LD_DONE);
      error_reg    <= (state_next == LD_ERR);
      cpu_hold_reg <= (state_next != LD_DONE);
      if (reload) begin
        word_index_reg <= '0;
        count_reg      <= '0;
      end else begin
        // Oversized counts go straight to LD_ERR, so the truncation here never matters.
        if ((state_reg == LD_LEN) && word_valid) begin
          count_reg <= word_data[ADDR_WIDTH:0];
        end
        if (imem_we_next) begin
          imem_addr_reg  <= word_index_reg;
          imem_wdata_reg <= word_data;
          if (!last_word) begin
            word_index_reg <= word_index_reg + INDEX_ONE;
          end
        end
      end
    end
  end

  assign bus.imem_we    = imem_we_reg;
  assign bus.imem_addr  = imem_addr_reg;
  assign bus.imem_wdata = imem_wdata_reg;
  assign done           = done_reg;
  assign error          = error_reg;
  assign cpu_hold       = cpu_hold_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal load, count/opcode errors, reload,
// gapped input and (with LOADER_CHECKSUM_EN) checksum match/mismatch.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reload = 1'b0;
  logic cpu_hold, done, error;

  program_loader_if #(.ADDR_WIDTH(10)) bus ();

  program_loader #(
    .IMEM_DEPTH (1024),
    .ADDR_WIDTH (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reload   (reload),
    .bus      (bus.master),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int pass_count = 0;
  int check_count = 0;
  int wr_count = 0;
  int wr_base = 0;
  logic [31:0] mem [0:1023];

  // Capture the write port as the memory would see it.
  always @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_addr] <= bus.imem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int n = 0; n < 16 && !got; n++) begin
      got = bus.rx_ready;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    if (!got) check("send_timeout", 32'(got), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    $display("tx word 0x%08h", w);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    $display("tx reload");
  endtask

  initial begin
    logic [7:0] gap_bytes [0:11];
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset state
    idle(2);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    idle(1);
    check("rst_ready", 32'(bus.rx_ready), 32'd1);

    // Load 2 words
    send_word(32'd2);
    check("hdr_ready", 32'(bus.rx_ready), 32'd1);
    send_word(32'h0010_0013);
    check("w0_we", 32'(bus.imem_we), 32'd1);
    check("w0_addr", 32'(bus.imem_addr), 32'd0);
    check("w0_data", bus.imem_wdata, 32'h0010_0013);
    send_byte(8'h93);
    check("we_pulse", 32'(bus.imem_we), 32'd0);
    check("addr_hold", 32'(bus.imem_addr), 32'd0);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    check("w1_we", 32'(bus.imem_we), 32'd1);
    check("w1_addr", 32'(bus.imem_addr), 32'd1);
    check("w1_data", bus.imem_wdata, 32'h0020_0093);
    check("ld2_done", 32'(done), 32'd1);
    check("ld2_hold", 32'(cpu_hold), 32'd0);
    check("ld2_ready", 32'(bus.rx_ready), 32'd0);
    idle(1);
    check("ld2_wrcnt", 32'(wr_count), 32'd2);
    check("ld2_mem0", mem[0], 32'h0010_0013);
    check("ld2_mem1", mem[1], 32'h0020_0093);

    // Bytes offered in LD_DONE are ignored
    wr_base = wr_count;
    bus.rx_data  = 8'h13;
    bus.rx_valid = 1'b1;
    idle(4);
    bus.rx_valid = 1'b0;
    check("done_stall_ready", 32'(bus.rx_ready), 32'd0);
    check("done_stall_done", 32'(done), 32'd1);
    check("done_stall_wrcnt", 32'(wr_count), 32'(wr_base));

    do_reload();
    check("rl_done", 32'(done), 32'd0);
    check("rl_hold", 32'(cpu_hold), 32'd1);
    check("rl_ready", 32'(bus.rx_ready), 32'd1);

    // Oversized count
    send_word(32'h0000_0401);
    check("big_error", 32'(error), 32'd1);
    check("big_ready", 32'(bus.rx_ready), 32'd0);
    check("big_hold", 32'(cpu_hold), 32'd1);
    idle(1);
    check("big_wrcnt", 32'(wr_count), 32'(wr_base));

    // Count equal to depth is legal
    do_reload();
    check("rl2_error", 32'(error), 32'd0);
    send_word(32'h0000_0400);
    check("max_error", 32'(error), 32'd0);
    check("max_ready", 32'(bus.rx_ready), 32'd1);

    // Bad opcode
    do_reload();
    send_word(32'd1);
    send_word(32'h0000_0010);
    check("bad_error", 32'(error), 32'd1);
    check("bad_we", 32'(bus.imem_we), 32'd0);
    check("bad_hold", 32'(cpu_hold), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    idle(1);
    check("bad_wrcnt", 32'(wr_count), 32'(wr_base));

    // Reload mid-word with a byte offered in the same cycle
    do_reload();
    send_word(32'd1);
    send_byte(8'h13);
    send_byte(8'h00);
    bus.rx_data  = 8'hFF;
    bus.rx_valid = 1'b1;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    bus.rx_valid = 1'b0;
    $display("tx reload with byte 0xff");
    check("mid_ready", 32'(bus.rx_ready), 32'd1);
    check("mid_hold", 32'(cpu_hold), 32'd1);
    send_word(32'd1);
    send_word(32'h0030_0193);
    check("mid_we", 32'(bus.imem_we), 32'd1);
    check("mid_addr", 32'(bus.imem_addr), 32'd0);
    check("mid_data", bus.imem_wdata, 32'h0030_0193);
    check("mid_done", 32'(done), 32'd1);
    idle(1);
    check("mid_mem0", mem[0], 32'h0030_0193);

    // Empty image
    do_reload();
    send_word(32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("n0_wait", 32'(done), 32'd0);
    send_byte(8'h00);
`endif
    check("n0_done", 32'(done), 32'd1);
    check("n0_we", 32'(bus.imem_we), 32'd0);

    // Gapped input: idle cycle between bytes
    do_reload();
    wr_base = wr_count;
    gap_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                  8'h93, 8'h00, 8'h20, 8'h00};
    for (int i = 0; i < 11; i++) begin
      send_byte(gap_bytes[i]);
      idle(1);
    end
    send_byte(gap_bytes[11]);
    $display("tx gapped image of 2 words");
`ifdef LOADER_CHECKSUM_EN
    check("gap_we", 32'(bus.imem_we), 32'd1);
    send_byte(8'h13 ^ 8'h10 ^ 8'h93 ^ 8'h20);
`else
    check("gap_we", 32'(bus.imem_we), 32'd1);
    check("gap_addr", 32'(bus.imem_addr), 32'd1);
`endif
    check("gap_done", 32'(done), 32'd1);
    idle(1);
    check("gap_wrcnt", 32'(wr_count), 32'(wr_base + 2));
    check("gap_mem0", mem[0], 32'h0010_0013);
    check("gap_mem1", mem[1], 32'h0020_0093);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match
    do_reload();
    send_word(32'd1);
    send_word(32'h0010_0013);
    check("cs_wait_done", 32'(done), 32'd0);
    check("cs_wait_ready", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h03);
    check("cs_ok_done", 32'(done), 32'd1);
    check("cs_ok_hold", 32'(cpu_hold), 32'd0);

    // Checksum mismatch; word already written
    do_reload();
    wr_base = wr_count;
    send_word(32'd1);
    send_word(32'h0010_0013);
    send_byte(8'h04);
    check("cs_bad_error", 32'(error), 32'd1);
    check("cs_bad_done", 32'(done), 32'd0);
    idle(1);
    check("cs_bad_wrcnt", 32'(wr_count), 32'(wr_base + 1));
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction memory. Receives a little-endian byte stream (length header, instruction words, optional checksum), assembles 32-bit instructions and writes them into instruction memory starting at word 0. Holds the core in reset until the image is complete. Sits between the byte receiver (UART RX) and the instruction-memory write port; the fetch stage is the reader of the same memory.

## Interface

**Parameters**
- `IMEM_DEPTH`, default 1024: instruction memory size in 32-bit words.
- `ADDR_WIDTH`, default 10: word-address width; must satisfy 2^ADDR_WIDTH >= IMEM_DEPTH.

**Ports**
- `clk` input, 1: the only clock.
- `reset` input, 1: synchronous, active-high.
- `reload` input, 1: single-cycle pulse that restarts a load from any state.
- `rx_data` input, 8: stream byte.
- `rx_valid` input, 1: `rx_data` is valid this cycle.
- `rx_ready` output, 1: loader accepts a byte this cycle.
- `imem_we` output, 1: instruction memory write strobe.
- `imem_addr` output, ADDR_WIDTH: word address.
- `imem_wdata` output, 32: instruction word.
- `cpu_hold` output, 1: holds the core in reset while high.
- `done` output, 1: image loaded successfully (level).
- `error` output, 1: load aborted (level).

## Operation

- A byte is accepted on a cycle with `rx_valid && rx_ready`. A byte offered while `rx_ready`=0 is ignored; the source holds it.
- **Stream format:** 4-byte word count N (LSB first), then N×4 instruction bytes (LSB first per word), then one checksum byte if `LOADER_CHECKSUM_EN` is defined.
- **States:**
  - `LD_LEN`: collect 4 count bytes. After the 4th byte:
    - N > IMEM_DEPTH → `LD_ERR`.
    - N = 0 → `LD_CSUM` if checksum is enabled, else `LD_DONE`.
    - Otherwise → `LD_DATA`.
  - `LD_DATA`: collect words. Each completed word is written to `imem_addr` = word index (0..N-1).
    - If a word's bits [1:0] ≠ 2'b11 (not a 32-bit RV instruction), the word is not written and the state goes to `LD_ERR`.
    - After word N-1 → `LD_CSUM` or `LD_DONE`.
  - `LD_CSUM`: one byte, compared against the XOR of all data bytes. Match → `LD_DONE`, mismatch → `LD_ERR`.
  - `LD_DONE`: `done`=1, `cpu_hold`=0, `rx_ready`=0.
  - `LD_ERR`: `error`=1, `cpu_hold`=1, `rx_ready`=0.
- `rx_ready`=1 in `LD_LEN`, `LD_DATA` and `LD_CSUM`.
- **`reload`:** from any state, go to `LD_LEN`; clear the byte counter, word index, count and checksum; drive `cpu_hold`=1. If `rx_valid` is high in the same cycle, that byte is dropped (reload wins).
- Memory contents from an aborted load are not cleared.
- Byte and word counters are sized to the maximum and never wrap. N is checked before any write, so `imem_addr` never exceeds IMEM_DEPTH-1.

## Timing

- **Reset values:** state `LD_LEN`, `rx_ready`=1 in the cycle after reset, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0.
- **Write latency:** `imem_we` is a registered one-cycle pulse in the cycle after the 4th byte of a word is accepted. `imem_addr` and `imem_wdata` are valid in that same cycle and hold until the next write.
- Full throughput is one byte per cycle. Back-to-back words produce `imem_we` every 4 cycles.
- `done`, `error` and `cpu_hold` are registered. They change in the cycle after the terminating byte is accepted, or the cycle after the `reload` edge.
- The last `imem_we` pulse and the `done` rise occur in the same cycle when checksum is disabled.

## Configuration

- `LOADER_CHECKSUM_EN` defined: the `LD_CSUM` state exists, a running XOR register covers all data bytes (header excluded), and a trailing byte is required.
- Undefined: no checksum register and no `LD_CSUM` state. `LD_DATA` and N=0 transition directly to `LD_DONE`.

## Structure

- The shared `common` package gains:
  - `loader_state_type` enum (`LD_LEN`, `LD_DATA`, `LD_CSUM`, `LD_DONE`, `LD_ERR`, logic [2:0]).
  - Constant `RV32_OPCODE_LOW = 2'b11`.
- One sub-module, `word_assembler`: a shift register plus 2-bit byte counter. It accepts bytes and emits a 32-bit word with a one-cycle `word_valid`, and has a clear input driven by `reload` and state entry.
- The top level holds the FSM, count/index registers, checksum and output registers.

## Test plan

- **Load 2 words:** bytes 02 00 00 00, 13 00 10 00, 93 00 20 00 → `imem_we` at addr 0 with 0x00100013, at addr 1 with 0x00200093; `done`=1, `cpu_hold`=0 one cycle after the last byte.
- **Oversized count:** N=0x00000401 with IMEM_DEPTH=1024 → `error`=1 after the 4th header byte, no `imem_we`, `rx_ready`=0.
- **Bad opcode:** N=1, word 0x00000010 → no write, `error`=1, `cpu_hold`=1.
- **Reload mid-word:** after 2 data bytes, pulse `reload` with `rx_valid`=1 → that byte dropped, state `LD_LEN`; a fresh N=1 load writes addr 0 correctly.
- **Gapped and stalled input:** `rx_valid` toggling every other cycle, and `rx_valid` while in `LD_DONE` → same memory image; no byte accepted in `LD_DONE`.
- **With `LOADER_CHECKSUM_EN`:** N=1, word 0x00100013, checksum byte 0x03 → `done`; checksum byte 0x04 → `error`, with addr 0 already written.
